add_err_monitor: RTL

- Downstream consumer of an approximate unsigned adder under test (8-bit A/B, 9-bit O).
- Each cycle it can accept one {A, B, O} sample via a valid/ready handshake and recomputes the exact sum.
- It accumulates error metrics over a programmable window: sample count, erroneous-sample count, sum of absolute error and maximum error.
- Used in place of dumping outputs to a file for on-chip or long-run error characterisation of approximate adders.

---
 rtl/add_err_monitor.sv | 115 +++++++++++
 1 files changed

// File: rtl/add_err_monitor.sv
// add_err_monitor: windowed error metrics for an approximate adder (count, errors, sum/max |err|); define ADD_ERR_MONITOR_SQ_EN to add sum_sq_err
module add_err_monitor #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16,
  parameter int ACC_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               clear,
  input  logic [CNT_W-1:0]   cfg_num,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [WIDTH:0]     in_o,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   sample_count,
  output logic [CNT_W-1:0]   err_count,
  output logic [ACC_W-1:0]   sum_abs_err,
  output logic [WIDTH:0]     max_err,
  output logic               sat,
  output logic [2*ACC_W-1:0] sum_sq_err
);
  localparam int SA = (ACC_W > WIDTH + 1 ? ACC_W : WIDTH + 1) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] target, accepted;
  logic v1;
  logic [WIDTH:0] err1, exact, err;
  logic signed [WIDTH+1:0] diff, mag;
  logic [SA-1:0] sa_sum;
  logic accept, last, go, zero, sa_ovf, sq_ovf;
  assign accept = in_valid && in_ready;
  assign last = accept && ((accepted + CNT_W'(1)) == target);
  assign go = start && (state == IDLE || (state == DONE && !clear));
  assign zero = go || (state == DONE && clear);
  assign exact = {1'b0, in_a} + {1'b0, in_b};
  assign diff = $signed({1'b0, in_o}) - $signed({1'b0, exact});
  assign mag = diff[WIDTH+1] ? -diff : diff;
  assign err = mag[WIDTH:0];
  assign sa_sum = SA'(sum_abs_err) + SA'(err1);
  assign sa_ovf = |sa_sum[SA-1:ACC_W];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? (cfg_num == '0 ? DONE : RUN) : IDLE;
      RUN:     state_nx = last ? DRAIN : RUN;
      DRAIN:   state_nx = v1 ? DRAIN : DONE;
      DONE:    state_nx = clear ? IDLE : start ? (cfg_num == '0 ? DONE : RUN) : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    in_ready = state == RUN;
    busy = state == RUN || state == DRAIN;
    done = state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      target <= '0;
      accepted <= '0;
      v1 <= 1'b0;
      err1 <= '0;
    end else begin
      v1 <= accept;
      if (accept) begin
        err1 <= err;
        accepted <= accepted + CNT_W'(1);
      end
      if (go) begin
        target <= cfg_num;
        accepted <= '0;
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sample_count <= '0;
      err_count <= '0;
      sum_abs_err <= '0;
      max_err <= '0;
      sat <= 1'b0;
    end else if (zero) begin
      sample_count <= '0;
      err_count <= '0;
      sum_abs_err <= '0;
      max_err <= '0;
      sat <= 1'b0;
    end else if (v1) begin
      sample_count <= sample_count + CNT_W'(1);
      err_count <= err_count + CNT_W'(err1 != '0);
      sum_abs_err <= sa_ovf ? '1 : sa_sum[ACC_W-1:0];
      max_err <= err1 > max_err ? err1 : max_err;
      sat <= sat | sa_ovf | sq_ovf;
    end
`ifdef ADD_ERR_MONITOR_SQ_EN
  localparam int SQ = (2*ACC_W > 2*WIDTH + 2 ? 2*ACC_W : 2*WIDTH + 2) + 1;
  logic [2*WIDTH+1:0] sq;
  logic [SQ-1:0] sq_sum;
  assign sq = {{(WIDTH+1){1'b0}}, err1} * {{(WIDTH+1){1'b0}}, err1};
  assign sq_sum = SQ'(sum_sq_err) + SQ'(sq);
  assign sq_ovf = |sq_sum[SQ-1:2*ACC_W];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sum_sq_err <= '0;
    else if (zero) sum_sq_err <= '0;
    else if (v1) sum_sq_err <= sq_ovf ? '1 : sq_sum[2*ACC_W-1:0];
`else
  assign sq_ovf = 1'b0;
  assign sum_sq_err = '0;
`endif
endmodule
